// File: rtl/percept_neuron.sv
// Single perceptron: serial signed features -> weighted sum + bias -> binary decision, with optional learning-rule update.
// Latency: out_valid one cycle after the last feature is accepted; a training update adds N_INPUTS+1 cycles of busy.
// Backpressure: x_ready is high only while accumulating; start, w_wr and x_valid are ignored whenever they cannot be served.
module percept_neuron #(
  parameter int N_INPUTS = 8,
  parameter int DATA_W   = 8,
  parameter int WEIGHT_W = 16,
  parameter int ACC_W    = 28,
  parameter int ADDR_W   = 4
) (
  input  logic                clk,
  input  logic                nRst,
  input  logic                start,
  input  logic                train,
  input  logic                target,
  input  logic                x_valid,
  input  logic [DATA_W-1:0]   x_data,
  output logic                x_ready,
  input  logic                w_wr,
  input  logic [ADDR_W-1:0]   w_addr,
  input  logic [WEIGHT_W-1:0] w_data,
  output logic [WEIGHT_W-1:0] w_rd_data,
  output logic                busy,
  output logic                out_valid,
  output logic                out_y,
  output logic [ACC_W-1:0]    acc_out,
  output logic                updated
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DECIDE, S_UPDATE} state_t;

  // Address of the bias slot and of the final weight, sized to the index width
  localparam logic [ADDR_W-1:0] LP_BIAS = ADDR_W'(N_INPUTS);
  localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(N_INPUTS - 1);
  localparam int                PROD_W  = WEIGHT_W + DATA_W;

  state_t                      r_state;
  logic [ADDR_W-1:0]           r_idx;
  logic signed [WEIGHT_W-1:0]  r_w    [0:N_INPUTS];  // slot N_INPUTS holds the bias
  logic signed [DATA_W-1:0]    r_xbuf [0:N_INPUTS];  // top slot is never written by a sample
  logic signed [ACC_W-1:0]     r_acc;
  logic                        r_train;
  logic                        r_target;
  logic                        r_out_valid;
  logic                        r_out_y;
  logic [ACC_W-1:0]            r_acc_out;
  logic                        r_updated;
  logic [WEIGHT_W-1:0]         r_rd_data;

  logic signed [PROD_W-1:0]    w_wext;
  logic signed [PROD_W-1:0]    w_xext;
  logic signed [PROD_W-1:0]    w_prod;
  logic signed [ACC_W-1:0]     w_prod_ext;
  logic signed [ACC_W-1:0]     w_bias_ext;
  logic signed [WEIGHT_W:0]    w_cur_ext;
  logic signed [WEIGHT_W:0]    w_xbuf_ext;
  logic signed [WEIGHT_W:0]    w_step;
  logic signed [WEIGHT_W:0]    w_sum;
  logic signed [WEIGHT_W-1:0]  w_sat;
  logic                        w_y;

  // Operands widened to the full product width so the multiply never truncates
  assign w_wext     = {{DATA_W{r_w[r_idx][WEIGHT_W-1]}}, r_w[r_idx]};
  assign w_xext     = {{WEIGHT_W{x_data[DATA_W-1]}}, x_data};
  assign w_prod     = w_wext * w_xext;
  assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
  assign w_bias_ext = {{(ACC_W-WEIGHT_W){r_w[N_INPUTS][WEIGHT_W-1]}}, r_w[N_INPUTS]};

  // Learning step: one guard bit detects overflow, then clamp to the weight range
  assign w_cur_ext  = {r_w[r_idx][WEIGHT_W-1], r_w[r_idx]};
  assign w_xbuf_ext = {{(WEIGHT_W+1-DATA_W){r_xbuf[r_idx][DATA_W-1]}}, r_xbuf[r_idx]};
  assign w_step     = (r_idx == LP_BIAS) ? (WEIGHT_W+1)'(1) : w_xbuf_ext;
  assign w_sum      = r_target ? (w_cur_ext + w_step) : (w_cur_ext - w_step);
  assign w_sat      = (w_sum[WEIGHT_W] != w_sum[WEIGHT_W-1])
                      ? (w_sum[WEIGHT_W] ? {1'b1, {(WEIGHT_W-1){1'b0}}} : {1'b0, {(WEIGHT_W-1){1'b1}}})
                      : w_sum[WEIGHT_W-1:0];

  assign w_y = ~r_acc[ACC_W-1];

  assign x_ready   = (r_state == S_ACCUM);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign out_y     = r_out_y;
  assign acc_out   = r_acc_out;
  assign updated   = r_updated;
  assign w_rd_data = r_rd_data;

  // Control FSM: accumulate samples, decide, then optionally walk the update sequence
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_acc       <= '0;
      r_train     <= 1'b0;
      r_target    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_y     <= 1'b0;
      r_acc_out   <= '0;
      r_updated   <= 1'b0;
      for (int i = 0; i <= N_INPUTS; i++) r_xbuf[i] <= '0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state  <= S_ACCUM;
            r_acc    <= w_bias_ext;
            r_idx    <= '0;
            r_train  <= train;
            r_target <= target;
          end
        end
        S_ACCUM: begin
          if (x_valid) begin
            r_acc         <= r_acc + w_prod_ext;
            r_xbuf[r_idx] <= $signed(x_data);
            if (r_idx == LP_LAST) begin
              r_idx   <= '0;
              r_state <= S_DECIDE;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        S_DECIDE: begin
          r_out_valid <= 1'b1;
          r_out_y     <= w_y;
          r_acc_out   <= r_acc;
          r_idx       <= '0;
          if (r_train && (w_y != r_target)) begin
            r_updated <= 1'b1;
            r_state   <= S_UPDATE;
          end else begin
            r_updated <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          if (r_idx == LP_BIAS) begin
            r_idx   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
      endcase
    end
  end

  // Weight store: host writes only while idle, learning writes one slot per update cycle
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      for (int i = 0; i <= N_INPUTS; i++) r_w[i] <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_wr && (w_addr <= LP_BIAS)) r_w[w_addr] <= $signed(w_data);
    end else if (r_state == S_UPDATE) begin
      r_w[r_idx] <= w_sat;
    end
  end

  // Registered host read of whatever the store holds now; unmapped addresses read zero
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= (w_addr <= LP_BIAS) ? r_w[w_addr] : '0;
    end
  end

endmodule

// File: tb/tb_percept_neuron.sv
module tb_percept_neuron;

  logic        clk = 1'b0;
  logic        nRst;
  logic        start;
  logic        train;
  logic        target;
  logic        x_valid;
  logic [7:0]  x_data;
  logic        x_ready;
  logic        w_wr;
  logic [3:0]  w_addr;
  logic [15:0] w_data;
  logic [15:0] w_rd_data;
  logic        busy;
  logic        out_valid;
  logic        out_y;
  logic [27:0] acc_out;
  logic        updated;

  always #5 clk = ~clk;

  percept_neuron dut (
    .clk       (clk),
    .nRst      (nRst),
    .start     (start),
    .train     (train),
    .target    (target),
    .x_valid   (x_valid),
    .x_data    (x_data),
    .x_ready   (x_ready),
    .w_wr      (w_wr),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .w_rd_data (w_rd_data),
    .busy      (busy),
    .out_valid (out_valid),
    .out_y     (out_y),
    .acc_out   (acc_out),
    .updated   (updated)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] xv [8];
  int         wv [9];

  logic        s_ov_early;
  logic        s_ov;
  logic        s_ov_late;
  logic        s_y;
  logic        s_upd;
  logic        s_busy;
  logic [27:0] s_acc;
  int          s_wait;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input int d);
    w_wr   = 1'b1;
    w_addr = 4'(a);
    w_data = 16'(d);
    tick;
    w_wr   = 1'b0;
  endtask

  task automatic load_all;
    for (int i = 0; i < 9; i++) wr(i, wv[i]);
  endtask

  task automatic read_chk(input string tag, input int a, input int exp);
    w_addr = 4'(a);
    tick;
    chk($sformatf("%s_rd%0d", tag, a), $signed(w_rd_data), exp);
  endtask

  task automatic set_x(input int a0, input int a1, input int a2, input int rest);
    xv[0] = 8'(a0);
    xv[1] = 8'(a1);
    xv[2] = 8'(a2);
    for (int i = 3; i < 8; i++) xv[i] = 8'(rest);
  endtask

  // Drives one full sample; poke pulses start and a weight write during the first gap cycle
  task automatic run_sample(input logic tr, input logic tg, input int gap, input bit poke);
    start  = 1'b1;
    train  = tr;
    target = tg;
    tick;
    start  = 1'b0;
    train  = 1'b0;
    target = 1'b0;
    for (int i = 0; i < 8; i++) begin
      x_valid = 1'b1;
      x_data  = xv[i];
      tick;
      x_valid = 1'b0;
      x_data  = 8'h00;
      if (i < 7) begin
        for (int g = 0; g < gap; g++) begin
          if (poke && g == 0) begin
            start  = 1'b1;
            w_wr   = 1'b1;
            w_addr = 4'd0;
            w_data = 16'd999;
          end
          tick;
          start = 1'b0;
          w_wr  = 1'b0;
        end
      end
    end
    s_ov_early = out_valid;
    tick;
    s_ov   = out_valid;
    s_y    = out_y;
    s_acc  = acc_out;
    s_upd  = updated;
    s_busy = busy;
    tick;
    s_ov_late = out_valid;
    s_wait = 0;
    while (busy && s_wait < 40) begin
      tick;
      s_wait++;
    end
  endtask

  task automatic check_sample(input string tag, input int e_acc, input int e_y, input int e_upd, input int e_wait);
    chk({tag, "_ov_early"}, s_ov_early, 0);
    chk({tag, "_ov"}, s_ov, 1);
    chk({tag, "_ov_late"}, s_ov_late, 0);
    chk({tag, "_acc"}, $signed(s_acc), e_acc);
    chk({tag, "_y"}, s_y, e_y);
    chk({tag, "_upd"}, s_upd, e_upd);
    chk({tag, "_busy"}, s_busy, e_upd);
    chk({tag, "_wait"}, s_wait, e_wait);
  endtask

  initial begin
    nRst = 1'b0; start = 1'b0; train = 1'b0; target = 1'b0;
    x_valid = 1'b0; x_data = 8'h00; w_wr = 1'b0; w_addr = 4'd0; w_data = 16'd0;
    tick;
    tick;
    nRst = 1'b1;
    tick;

    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_y", out_y, 0);
    chk("rst_acc", $signed(acc_out), 0);
    chk("rst_upd", updated, 0);
    chk("rst_xrdy", x_ready, 0);
    for (int a = 0; a < 9; a++) read_chk("t1", a, 0);
    set_x(1, 1, 1, 1);
    run_sample(1'b0, 1'b0, 0, 1'b0);
    check_sample("t1", 0, 1, 0, 0);

    // Plain inference: 36 - 40
    for (int i = 0; i < 8; i++) wv[i] = i + 1;
    wv[8] = -40;
    load_all;
    run_sample(1'b0, 1'b0, 0, 1'b0);
    check_sample("t2", -4, 0, 0, 0);

    // Training toward target 1, then re-infer: 44 - 39
    run_sample(1'b1, 1'b1, 0, 1'b0);
    check_sample("t3", -4, 0, 1, 8);
    for (int a = 0; a < 8; a++) read_chk("t3", a, a + 2);
    read_chk("t3", 8, -39);
    run_sample(1'b0, 1'b0, 0, 1'b0);
    check_sample("t3b", 5, 1, 0, 0);

    // Saturation a: large positive sum, target already met
    wv = '{32767, 0, 0, 0, 0, 0, 0, 0, -1};
    load_all;
    set_x(5, 0, 0, 0);
    run_sample(1'b1, 1'b1, 0, 1'b0);
    check_sample("t4a", 163834, 1, 0, 0);
    read_chk("t4a", 0, 32767);

    // Saturation b: w0=-32768, x0=5, target 1 -> w0=-32763, bias 0->1
    wr(0, -32768);
    wr(8, 0);
    run_sample(1'b1, 1'b1, 0, 1'b0);
    check_sample("t4b", -163840, 0, 1, 8);
    read_chk("t4b", 0, -32763);
    read_chk("t4b", 8, 1);
    read_chk("t4b", 1, 0);

    // Saturation c: w0=-32768, x0=-5, target 0 -> w0=-32763, bias 0->-1
    wr(0, -32768);
    wr(8, 0);
    set_x(-5, 0, 0, 0);
    run_sample(1'b1, 1'b0, 0, 1'b0);
    check_sample("t4c", 163840, 1, 1, 8);
    read_chk("t4c", 0, -32763);
    read_chk("t4c", 8, -1);

    // Saturation d: clamps at both ends for weights and bias
    wv = '{32767, -32768, -32768, 0, 0, 0, 0, 0, -32768};
    load_all;
    set_x(-5, -128, 1, 0);
    run_sample(1'b1, 1'b0, 0, 1'b0);
    check_sample("t4d", 3964933, 1, 1, 8);
    read_chk("t4d", 0, 32767);
    read_chk("t4d", 1, -32640);
    read_chk("t4d", 2, -32768);
    read_chk("t4d", 3, 0);
    read_chk("t4d", 8, -32768);

    // Stalls with start and w_wr pulsed mid-sample
    for (int i = 0; i < 8; i++) wv[i] = i + 1;
    wv[8] = -40;
    load_all;
    set_x(1, 1, 1, 1);
    run_sample(1'b0, 1'b0, 3, 1'b1);
    check_sample("t5", -4, 0, 0, 0);
    read_chk("t5", 0, 1);

    // x_valid while idle must not advance anything
    x_valid = 1'b1;
    x_data  = 8'd100;
    tick;
    tick;
    tick;
    chk("t5_idle_busy", busy, 0);
    chk("t5_idle_xrdy", x_ready, 0);
    x_valid = 1'b0;
    x_data  = 8'h00;
    run_sample(1'b0, 1'b0, 0, 1'b0);
    check_sample("t5b", -4, 0, 0, 0);

    // Reset after four samples
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      x_valid = 1'b1;
      x_data  = 8'd1;
      tick;
    end
    x_valid = 1'b0;
    chk("t6_busy_pre", busy, 1);
    nRst = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_ov", out_valid, 0);
    chk("t6_xrdy", x_ready, 0);
    tick;
    chk("t6_ov_hold", out_valid, 0);
    nRst = 1'b1;
    tick;
    chk("t6_ov_after", out_valid, 0);
    for (int a = 0; a < 9; a++) read_chk("t6", a, 0);
    run_sample(1'b0, 1'b0, 0, 1'b0);
    check_sample("t6b", 0, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
